// File: rtl/cond_pkg.sv
// Shared definitions for the flag/condition unit: ARMv8 condition codes
// and the bit positions of N, Z, C, V inside the packed flag vector.
package cond_pkg;

   typedef enum logic [3:0] {
      EQ = 4'h0,
      NE = 4'h1,
      CS = 4'h2,
      CC = 4'h3,
      MI = 4'h4,
      PL = 4'h5,
      VS = 4'h6,
      VC = 4'h7,
      HI = 4'h8,
      LS = 4'h9,
      GE = 4'hA,
      LT = 4'hB,
      GT = 4'hC,
      LE = 4'hD,
      AL = 4'hE,
      NV = 4'hF
   } cond_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARMv8 condition-code evaluator: pass is 1 when the given
// condition holds for the supplied N, Z, C, V flags.
module cond_eval
   import cond_pkg::*;
(
   input  logic [3:0] cond,
   input  logic       N,
   input  logic       Z,
   input  logic       C,
   input  logic       V,
   output logic       pass
);

   // Decode the condition against the flags; AL and NV both always pass.
   always_comb begin
      pass = 1'b1;
      case (cond_e'(cond))
         EQ:      pass = Z;
         NE:      pass = ~Z;
         CS:      pass = C;
         CC:      pass = ~C;
         MI:      pass = N;
         PL:      pass = ~N;
         VS:      pass = V;
         VC:      pass = ~V;
         HI:      pass = C & ~Z;
         LS:      pass = ~C | Z;
         GE:      pass = (N == V);
         LT:      pass = (N != V);
         GT:      pass = ~Z & (N == V);
         LE:      pass = Z | (N != V);
         AL:      pass = 1'b1;
         NV:      pass = 1'b1;
         default: pass = 1'b1;
      endcase
   end

endmodule

// File: rtl/flag_cond_unit.sv
// NZCV flag register plus registered B.cond decision, with optional
// same-cycle forwarding of ALU flags into the branch evaluation.
module flag_cond_unit
   import cond_pkg::*;
#(
   parameter int FORWARD = 1
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       alu_negative,
   input  logic       alu_zero,
   input  logic       alu_overflow,
   input  logic       alu_carry,
   input  logic       set_flags,
   input  logic       ex_valid,
   input  logic       cond_req,
   input  logic [3:0] cond,
   input  logic       stall,
   output logic [3:0] flags,
   output logic       br_valid,
   output logic       br_taken
);

   localparam logic FWD_EN = (FORWARD != 0);

   logic [3:0] flags_r;
   logic       br_valid_r;
   logic       br_taken_r;

   logic [3:0] live_flags_s;
   logic       flag_src_s;
   logic       flag_wr_s;
   logic [3:0] eff_flags_s;
   logic       pass_s;

   assign live_flags_s = {alu_negative, alu_zero, alu_carry, alu_overflow};

   // A bubble never produces flags, so it can neither write nor forward them.
   assign flag_src_s = ex_valid & set_flags;
   assign flag_wr_s  = flag_src_s & ~stall;

   // Select the flag view used by the branch this cycle.
   always_comb begin
      eff_flags_s = flags_r;
      if (FWD_EN && flag_src_s) begin
         eff_flags_s = live_flags_s;
      end else begin
         eff_flags_s = flags_r;
      end
   end

   cond_eval u_cond_eval (
      .cond (cond),
      .N    (eff_flags_s[FLAG_N]),
      .Z    (eff_flags_s[FLAG_Z]),
      .C    (eff_flags_s[FLAG_C]),
      .V    (eff_flags_s[FLAG_V]),
      .pass (pass_s)
   );

   // Flag register: load on a real flag-setting instruction unless frozen.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_r <= 4'b0000;
      end else if (flag_wr_s) begin
         flags_r <= live_flags_s;
      end else begin
         flags_r <= flags_r;
      end
   end

   // Decision register: one-cycle latency, held while stalled, taken qualified by valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         br_valid_r <= 1'b0;
         br_taken_r <= 1'b0;
      end else if (!stall) begin
         br_valid_r <= cond_req;
         br_taken_r <= cond_req & pass_s;
      end else begin
         br_valid_r <= br_valid_r;
         br_taken_r <= br_taken_r;
      end
   end

   assign flags    = flags_r;
   assign br_valid = br_valid_r;
   assign br_taken = br_taken_r;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Self-checking bench for flag_cond_unit: forwarding and registered-only
// instances driven in parallel, directed vectors, stall/reset sequences and a full sweep.
module tb_flag_cond_unit;

   typedef struct packed {
      logic [3:0] live;
      logic       sf;
      logic       ev;
      logic       cr;
      logic [3:0] cd;
      logic       st;
      logic [3:0] e_flags;
      logic       e_valid;
      logic       e_t1;
      logic       e_t0;
   } vec_t;

   typedef struct packed {
      logic [3:0] flags;
      logic       valid;
      logic       t1;
      logic       t0;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       alu_negative = 1'b0;
   logic       alu_zero = 1'b0;
   logic       alu_overflow = 1'b0;
   logic       alu_carry = 1'b0;
   logic       set_flags = 1'b0;
   logic       ex_valid = 1'b0;
   logic       cond_req = 1'b0;
   logic [3:0] cond = 4'h0;
   logic       stall = 1'b0;

   logic [3:0] flags1, flags0;
   logic       br_valid1, br_valid0, br_taken1, br_taken0;

   int checks = 0;
   int errors = 0;

   exp_t sb_q[$];

   logic [3:0] m_flags = 4'b0000;
   logic       m_valid = 1'b0;
   logic       m_t1 = 1'b0;
   logic       m_t0 = 1'b0;

   vec_t vt[16];

   always #5 clk = ~clk;

   flag_cond_unit #(.FORWARD(1)) dut_fwd (
      .clk(clk), .reset(reset),
      .alu_negative(alu_negative), .alu_zero(alu_zero),
      .alu_overflow(alu_overflow), .alu_carry(alu_carry),
      .set_flags(set_flags), .ex_valid(ex_valid),
      .cond_req(cond_req), .cond(cond), .stall(stall),
      .flags(flags1), .br_valid(br_valid1), .br_taken(br_taken1)
   );

   flag_cond_unit #(.FORWARD(0)) dut_reg (
      .clk(clk), .reset(reset),
      .alu_negative(alu_negative), .alu_zero(alu_zero),
      .alu_overflow(alu_overflow), .alu_carry(alu_carry),
      .set_flags(set_flags), .ex_valid(ex_valid),
      .cond_req(cond_req), .cond(cond), .stall(stall),
      .flags(flags0), .br_valid(br_valid0), .br_taken(br_taken0)
   );

   // Reference condition table, organised by condition pair with bit 0 inverting.
   function automatic logic ref_eval(input logic [3:0] cd, input logic [3:0] f);
      logic n, z, c, v, base;
      n = f[3]; z = f[2]; c = f[1]; v = f[0];
      case (cd[3:1])
         3'd0:    base = z;
         3'd1:    base = c;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = c & ~z;
         3'd5:    base = (n == v);
         3'd6:    base = ~z & (n == v);
         default: base = 1'b1;
      endcase
      if (cd[0] && (cd[3:1] != 3'b111)) ref_eval = ~base;
      else ref_eval = base;
   endfunction

   function automatic vec_t mk(input logic [3:0] live, input logic sf, input logic ev,
                               input logic cr, input logic [3:0] cd, input logic st,
                               input logic [3:0] ef, input logic evl,
                               input logic t1, input logic t0);
      vec_t v;
      v.live = live; v.sf = sf; v.ev = ev; v.cr = cr; v.cd = cd; v.st = st;
      v.e_flags = ef; v.e_valid = evl; v.e_t1 = t1; v.e_t0 = t0;
      return v;
   endfunction

   task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s scoreboard empty", tag);
      end else begin
         e = sb_q.pop_front();
         cmp({tag, "_flags_fwd"}, flags1, e.flags);
         cmp({tag, "_valid_fwd"}, {3'b000, br_valid1}, {3'b000, e.valid});
         cmp({tag, "_taken_fwd"}, {3'b000, br_taken1}, {3'b000, e.t1});
         cmp({tag, "_flags_reg"}, flags0, e.flags);
         cmp({tag, "_valid_reg"}, {3'b000, br_valid0}, {3'b000, e.valid});
         cmp({tag, "_taken_reg"}, {3'b000, br_taken0}, {3'b000, e.t0});
      end
   endtask

   task automatic check_zero(input string tag);
      cmp({tag, "_flags_fwd"}, flags1, 4'b0000);
      cmp({tag, "_valid_fwd"}, {3'b000, br_valid1}, 4'b0000);
      cmp({tag, "_taken_fwd"}, {3'b000, br_taken1}, 4'b0000);
      cmp({tag, "_flags_reg"}, flags0, 4'b0000);
      cmp({tag, "_valid_reg"}, {3'b000, br_valid0}, 4'b0000);
      cmp({tag, "_taken_reg"}, {3'b000, br_taken0}, 4'b0000);
   endtask

   task automatic drive_idle();
      {alu_negative, alu_zero, alu_carry, alu_overflow} = 4'b0000;
      set_flags = 1'b0; ex_valid = 1'b0; cond_req = 1'b0; cond = 4'h0; stall = 1'b0;
   endtask

   // Drive one cycle, advance the model, push the expectation, check after the edge.
   task automatic run_vec(input vec_t v, input bit use_model, input string tag);
      exp_t e;
      logic [3:0] eff;
      @(negedge clk);
      {alu_negative, alu_zero, alu_carry, alu_overflow} = v.live;
      set_flags = v.sf; ex_valid = v.ev; cond_req = v.cr; cond = v.cd; stall = v.st;
      eff = (v.ev & v.sf) ? v.live : m_flags;
      if (!v.st) begin
         m_valid = v.cr;
         m_t1 = v.cr & ref_eval(v.cd, eff);
         m_t0 = v.cr & ref_eval(v.cd, m_flags);
         if (v.ev & v.sf) m_flags = v.live;
      end
      if (use_model) e = '{m_flags, m_valid, m_t1, m_t0};
      else e = '{v.e_flags, v.e_valid, v.e_t1, v.e_t0};
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      //          live     sf    ev    cr    cond   st    flags   v     t1    t0
      vt[0]  = mk(4'b1000, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0);
      vt[1]  = mk(4'b0100, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0);
      vt[2]  = mk(4'b0000, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b1);
      vt[3]  = mk(4'b0000, 1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
      vt[4]  = mk(4'b1111, 1'b1, 1'b0, 1'b1, 4'h4, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
      vt[5]  = mk(4'b0000, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      vt[6]  = mk(4'b0100, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b0);
      vt[7]  = mk(4'b0000, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      vt[8]  = mk(4'b1111, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      vt[9]  = mk(4'b0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      vt[10] = mk(4'b0001, 1'b1, 1'b1, 1'b1, 4'hA, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1);
      vt[11] = mk(4'b0000, 1'b0, 1'b1, 1'b1, 4'hE, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b1);
      vt[12] = mk(4'b0110, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 4'b0110, 1'b1, 1'b1, 1'b1);
      vt[13] = mk(4'b0000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0);
      vt[14] = mk(4'b0000, 1'b0, 1'b1, 1'b1, 4'h8, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0);
      vt[15] = mk(4'b0000, 1'b0, 1'b1, 1'b1, 4'h9, 1'b0, 4'b0110, 1'b1, 1'b1, 1'b1);

      drive_idle();
      reset = 1'b1;
      #1;
      check_zero("reset_async");
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         run_vec(vt[i], 1'b0, $sformatf("vec%0d", i));
      end

      // Stall with a pending true decision: everything frozen, then release.
      for (int i = 0; i < 3; i++) begin
         run_vec(mk(4'b1001, 1'b1, 1'b1, 1'b1, 4'h1, 1'b1, 4'b0110, 1'b1, 1'b1, 1'b1),
                 1'b0, $sformatf("stall%0d", i));
      end
      run_vec(mk(4'b0000, 1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0),
              1'b0, "stall_release");
      run_vec(mk(4'b0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0),
              1'b0, "idle_after_stall");
      run_vec(mk(4'b1111, 1'b1, 1'b1, 1'b1, 4'hE, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0),
              1'b0, "stall_invalid_hold");

      // Full sweep: live flags forwarded to one instance, previous flags to the other.
      for (int c = 0; c < 16; c++) begin
         for (int f = 0; f < 16; f++) begin
            if (c == 8 && f == 0) begin
               reset = 1'b1;
               #1;
               check_zero("reset_mid_sweep");
               sb_q.delete();
               m_flags = 4'b0000; m_valid = 1'b0; m_t1 = 1'b0; m_t0 = 1'b0;
               @(negedge clk);
               {alu_negative, alu_zero, alu_carry, alu_overflow} = 4'b1111;
               set_flags = 1'b1; ex_valid = 1'b1; cond_req = 1'b1; cond = 4'hE;
               @(posedge clk);
               #1;
               check_zero("reset_held_edge");
               @(negedge clk);
               drive_idle();
               reset = 1'b0;
            end
            run_vec(mk(4'(f), 1'b1, 1'b1, 1'b1, 4'(c), 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0),
                    1'b1, $sformatf("sweep_c%0d_f%0d", c, f));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
